mem_bus_responder: RTL and testbench
====================================

# mem_bus_responder

Memory-side target for the 6502 core's multiplexed external bus. It demultiplexes the 8-bit address stream into a 16-bit address: high byte in the high phase, low byte in the low phase. It then serves one read or write per bus cycle from a small internal byte array. It sits outside the CPU on the bench or board side, with its inputs driven by the core's `uo_out`/`uio_out` and its data returned on the core's `uio_in`.

## Interface
- `DEPTH_LOG2`, 5, log2 of array size in bytes (32 bytes).
- `BASE_HI`, 8'h00, address high byte the array responds to.
- `FILL`, 8'hEA, byte returned on reads that miss the array.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `addr_mux_in` in 8: multiplexed address byte from the core.
- `phase` in 1: 1 means the high-byte phase, 0 means the low-byte phase.
- `rw` in 1: 0 means read, 1 means write. Sampled with the low byte.
- `data_in` in 8: write data from the core. Sampled in ACC.
- `ld_en` in 1: preload strobe.
- `ld_addr` in DEPTH_LOG2: preload index.
- `ld_data` in 8: preload byte.
- `data_out` out 8: read data to the core.
- `data_oe` out 1: data_out valid/driven.
- `hit` out 1: last completed access fell inside the array.
- `addr_out` out 16: last captured full address.
- `acc_count` out 8: completed access counter.

## Operation
- State machine: IDLE, HI, ACC.
- Edge detection: `phase_q` holds `phase` registered. A rise is `phase & ~phase_q`.
- IDLE:
  - On a rise: `abh_r <= addr_mux_in`, `data_oe <= 0`, go to HI.
  - Otherwise stay in IDLE.
- HI:
  - While `phase`=1: hold; no re-capture.
  - When `phase`=0: `abl_r <= addr_mux_in`, `rw_r <= rw`, go to ACC.
- ACC lasts exactly one cycle.
  - Index is `abl_r[DEPTH_LOG2-1:0]`.
  - Match is `abh_r==BASE_HI && abl_r[7:DEPTH_LOG2]==0`.
  - Read: `data_out <= match ? mem[idx] : FILL`, `data_oe <= 1`, `hit <= match`.
  - Write: if match, `mem[idx] <= data_in`; `data_oe <= 0`, `hit <= match`.
  - In both cases: `acc_count <= acc_count+1` (wraps 8'hFF to 8'h00), `addr_out <= {abh_r,abl_r}`.
  - Next state is HI if a rise occurs this cycle (capture `abh_r`, clear `data_oe`), else IDLE.
- `data_out` holds its value until the next read completes. `data_oe` stays 1 until the next rise.
- Preload: when `ld_en`=1, `mem[ld_addr] <= ld_data` in any state.
  - If a preload and a bus write target the same index in the same cycle, the preload wins.
  - A bus read in the same cycle as a preload to the same index returns the old byte.

## Timing
- Reset (async assert, sync-safe deassert):
  - State IDLE, `phase_q`=0.
  - `data_out`=8'h00, `data_oe`=0, `hit`=0.
  - `addr_out`=16'h0000, `acc_count`=8'h00.
  - All array bytes 8'h00.
- Reset mid-access aborts with no array write and no counter increment.
- Latency: read data is valid on the cycle after `phase` is first sampled low in HI. That is 2 clocks after the rise is sampled, for a minimal 1-clock high phase.
- Minimum bus cycle is 3 clocks (rise, low capture, ACC). Back-to-back cycles with a rise during ACC lose nothing.
- The low byte and `rw` must be stable on the first clock `phase` is 0. `data_in` must be stable one clock later (ACC).
- Entering with `phase`=1 out of reset: `phase_q`=0, so the first sampled 1 counts as a rise.

## Configuration
- Macro `MEM_BUS_WRITE_EN`.
- Defined: bus writes (`rw`=1) update the array as described.
- Undefined: the array is ROM from the bus side.
  - Writes still advance `acc_count` and update `addr_out`/`hit`, but never modify the array.
  - `data_oe` still goes 0 for write cycles.
  - Preload remains functional.

## Test plan
- Reset: assert `rst_n`=0 mid-HI, release, then read 16'h0003. Required response: `data_out`=8'h00, `data_oe`=1, `hit`=1, `acc_count`=1.
- Preload/read: preload idx 5 with 8'hA9, then bus-read 16'h0005. Required response: `data_out`=8'hA9 two clocks after the rise, `addr_out`=16'h0005, `hit`=1.
- Miss: read 16'h0120, then read 16'h0045. Required response: `data_out`=8'hEA and `hit`=0 for both.
- Write with `MEM_BUS_WRITE_EN`: write 8'h5C to 16'h001F, then read it back. Required response: 8'h5C. Without the macro, the readback is the preloaded or reset value 8'h00.
- Collision and back-to-back: assert a rise during ACC, and in the same cycle preload idx 2 with 8'h11 while a bus write of 8'h22 targets 16'h0002. Required response: no cycle lost, and idx 2 reads back 8'h11.
- Counter wrap: perform 256 accesses. Required response: `acc_count` returns to 8'h00.

Source files
------------

// File: rtl/mem_bus_if.sv
// mem_bus_if: multiplexed 6502 external bus between the core (master) and a memory-side target (slave).
// Signals:
//   addr_mux_in - address byte, high byte while phase=1, low byte while phase=0
//   phase       - 1 = high-byte phase, 0 = low-byte phase
//   rw          - 0 = read, 1 = write (valid with the low byte)
//   data_in     - write data from the core
//   data_out    - read data back to the core
//   data_oe     - data_out valid/driven
interface mem_bus_if;
    logic [7:0] addr_mux_in;
    logic       phase;
    logic       rw;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    modport master (output addr_mux_in, phase, rw, data_in, input data_out, data_oe);
    modport slave (input addr_mux_in, phase, rw, data_in, output data_out, data_oe);
endinterface

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side target that demultiplexes the 6502 address stream and serves one access per bus cycle.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   bus (slave)      - multiplexed address/phase/rw/data bus, see mem_bus_if
//   ld_en/addr/data  - preload port into the byte array, usable in any state
//   hit              - last completed access fell inside the array
//   addr_out         - last captured full address
//   acc_count        - completed access counter (wraps)
// Build option: define MEM_BUS_WRITE_EN to let bus writes modify the array; otherwise it is ROM from the bus side.
module mem_bus_responder #(
    parameter int         DEPTH_LOG2 = 5,
    parameter logic [7:0] BASE_HI    = 8'h00,
    parameter logic [7:0] FILL       = 8'hEA
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_bus_if.slave              bus,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [7:0]            ld_data,
    output logic                  hit,
    output logic [15:0]           addr_out,
    output logic [7:0]            acc_count
);
    typedef enum logic [1:0] {IDLE, HI, ACC} state_t;
    state_t state, state_nx;
    logic phase_q, rise, cap_hi, cap_lo, acc, match, rw_r;
    logic [7:0] abh_r, abl_r;
    logic [7:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    assign rise  = bus.phase & ~phase_q;
    assign idx   = abl_r[DEPTH_LOG2-1:0];
    assign match = abh_r == BASE_HI && abl_r[7:DEPTH_LOG2] == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            phase_q <= 1'b0;
        end else begin
            state   <= state_nx;
            phase_q <= bus.phase;
        end
    end
    // ACC is a single cycle; a rise seen during it chains straight into the next cycle's HI.
    always_comb begin
        state_nx = state;
        cap_hi   = 1'b0;
        cap_lo   = 1'b0;
        acc      = 1'b0;
        case (state)
            IDLE: begin
                cap_hi   = rise;
                state_nx = rise ? HI : IDLE;
            end
            HI: begin
                cap_lo   = ~bus.phase;
                state_nx = bus.phase ? HI : ACC;
            end
            ACC: begin
                acc      = 1'b1;
                cap_hi   = rise;
                state_nx = rise ? HI : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Later assignments win: a rise during ACC clears data_oe, and a preload beats a bus write to the same byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abh_r        <= '0;
            abl_r        <= '0;
            rw_r         <= 1'b0;
            bus.data_out <= '0;
            bus.data_oe  <= 1'b0;
            hit          <= 1'b0;
            addr_out     <= '0;
            acc_count    <= '0;
            for (int i = 0; i < 2**DEPTH_LOG2; i++) mem[i] <= '0;
        end else begin
            if (acc) begin
                hit         <= match;
                acc_count   <= acc_count + 8'd1;
                addr_out    <= {abh_r, abl_r};
                bus.data_oe <= ~rw_r;
                if (!rw_r) bus.data_out <= match ? mem[idx] : FILL;
`ifdef MEM_BUS_WRITE_EN
                if (rw_r && match) mem[idx] <= bus.data_in;
`endif
            end
            if (cap_hi) begin
                abh_r       <= bus.addr_mux_in;
                bus.data_oe <= 1'b0;
            end
            if (cap_lo) begin
                abl_r <= bus.addr_mux_in;
                rw_r  <= bus.rw;
            end
            if (ld_en) mem[ld_addr] <= ld_data;
        end
    end
`ifndef MEM_BUS_WRITE_EN
    logic unused_data_in;
    assign unused_data_in = ^bus.data_in;
`endif
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: self-checking bench for mem_bus_responder (table vectors, corner sequences, randomized vs. transaction model).
module tb_mem_bus_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_en = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        hit;
    logic [15:0] addr_out;
    logic [7:0]  acc_count;
    int checks = 0;
    int failures = 0;
`ifdef MEM_BUS_WRITE_EN
    localparam bit WE = 1'b1;
`else
    localparam bit WE = 1'b0;
`endif
    mem_bus_if bus();
    mem_bus_responder dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .hit(hit), .addr_out(addr_out), .acc_count(acc_count)
    );
    always #5 clk = ~clk;

    // Transaction-level model: one call per completed bus access.
    logic [7:0]  ref_mem [32];
    logic [7:0]  ref_dout = '0;
    logic [7:0]  ref_cnt = '0;
    logic        ref_oe = 1'b0;
    logic        ref_hit = 1'b0;
    logic [15:0] ref_addr = '0;

    typedef struct {
        logic [15:0] addr;
        logic        w;
        logic [7:0]  wd;
        logic [7:0]  dout;
        logic        hit;
        logic        oe;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ref_access(input logic [15:0] a, input logic w, input logic [7:0] d);
        ref_hit = a < 16'd32;
        ref_oe  = !w;
        if (!w) ref_dout = ref_hit ? ref_mem[a[4:0]] : 8'hEA;
        else if (WE && ref_hit) ref_mem[a[4:0]] = d;
        ref_cnt  = ref_cnt + 8'd1;
        ref_addr = a;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_dout"}, bus.data_out, ref_dout);
        chk({tag, "_oe"}, bus.data_oe, ref_oe);
        chk({tag, "_hit"}, hit, ref_hit);
        chk({tag, "_addr"}, addr_out, ref_addr);
        chk({tag, "_cnt"}, acc_count, ref_cnt);
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Minimal 3-clock bus cycle; returns at the negedge after ACC with the model updated.
    task automatic bus_cycle(input logic [15:0] a, input logic w, input logic [7:0] d);
        @(negedge clk);
        bus.phase = 1'b1;
        bus.addr_mux_in = a[15:8];
        @(negedge clk);
        bus.phase = 1'b0;
        bus.addr_mux_in = a[7:0];
        bus.rw = w;
        @(negedge clk);
        bus.data_in = d;
        @(negedge clk);
        ref_access(a, w, d);
    endtask

    initial begin
        logic [15:0] a;
        logic w;
        logic [7:0] d;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        bus.phase = 1'b0;
        bus.addr_mux_in = '0;
        bus.rw = 1'b0;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all("reset");

        // Reset while in HI aborts the access.
        @(negedge clk);
        bus.phase = 1'b1;
        bus.addr_mux_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        bus.phase = 1'b0;
        bus.addr_mux_in = 8'h03;
        bus.rw = 1'b1;
        bus.data_in = 8'h77;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midhi_reset_cnt", acc_count, 8'h00);
        chk("midhi_reset_oe", bus.data_oe, 1'b0);
        bus_cycle(16'h0003, 1'b0, 8'h00);
        chk("rst_read_dout", bus.data_out, 8'h00);
        chk("rst_read_oe", bus.data_oe, 1'b1);
        chk("rst_read_hit", hit, 1'b1);
        chk("rst_read_cnt", acc_count, 8'h01);

        // Preload then read with clock-by-clock latency checks.
        preload(5'd5, 8'hA9);
        @(negedge clk);
        bus.phase = 1'b1;
        bus.addr_mux_in = 8'h00;
        @(negedge clk);
        chk("oe_clear_on_rise", bus.data_oe, 1'b0);
        chk("dout_hold", bus.data_out, 8'h00);
        bus.phase = 1'b0;
        bus.addr_mux_in = 8'h05;
        bus.rw = 1'b0;
        @(negedge clk);
        chk("dout_not_early", bus.data_out, 8'h00);
        @(negedge clk);
        ref_access(16'h0005, 1'b0, 8'h00);
        chk("preload_dout", bus.data_out, 8'hA9);
        chk("preload_addr", addr_out, 16'h0005);
        chk("preload_hit", hit, 1'b1);

        vt[0] = '{16'h0120, 1'b0, 8'h00, 8'hEA, 1'b0, 1'b1};
        vt[1] = '{16'h0045, 1'b0, 8'h00, 8'hEA, 1'b0, 1'b1};
        vt[2] = '{16'h001F, 1'b1, 8'h5C, 8'hEA, 1'b1, 1'b0};
        vt[3] = '{16'h001F, 1'b0, 8'h00, WE ? 8'h5C : 8'h00, 1'b1, 1'b1};
        vt[4] = '{16'h0020, 1'b0, 8'h00, 8'hEA, 1'b0, 1'b1};
        vt[5] = '{16'h0000, 1'b1, 8'h33, 8'hEA, 1'b1, 1'b0};
        vt[6] = '{16'h0000, 1'b0, 8'h00, WE ? 8'h33 : 8'h00, 1'b1, 1'b1};
        vt[7] = '{16'h0005, 1'b0, 8'h00, 8'hA9, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            bus_cycle(vt[i].addr, vt[i].w, vt[i].wd);
            chk($sformatf("vec%0d_dout", i), bus.data_out, vt[i].dout);
            chk($sformatf("vec%0d_hit", i), hit, vt[i].hit);
            chk($sformatf("vec%0d_oe", i), bus.data_oe, vt[i].oe);
            chk($sformatf("vec%0d_addr", i), addr_out, vt[i].addr);
            chk($sformatf("vec%0d_cnt", i), acc_count, 8'(3 + i));
        end

        // Write ACC with a simultaneous rise and a colliding preload; the preload must win.
        @(negedge clk);
        bus.phase = 1'b1;
        bus.addr_mux_in = 8'h00;
        @(negedge clk);
        bus.phase = 1'b0;
        bus.addr_mux_in = 8'h02;
        bus.rw = 1'b1;
        @(negedge clk);
        bus.data_in = 8'h22;
        ld_en = 1'b1;
        ld_addr = 5'd2;
        ld_data = 8'h11;
        bus.phase = 1'b1;
        bus.addr_mux_in = 8'h00;
        @(negedge clk);
        ld_en = 1'b0;
        bus.phase = 1'b0;
        bus.addr_mux_in = 8'h02;
        bus.rw = 1'b0;
        ref_access(16'h0002, 1'b1, 8'h22);
        ref_mem[2] = 8'h11;
        check_all("b2b_wr");
        @(negedge clk);
        @(negedge clk);
        ref_access(16'h0002, 1'b0, 8'h00);
        check_all("b2b_rd");
        chk("collision_dout", bus.data_out, 8'h11);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) preload(5'($urandom_range(0, 31)), 8'($urandom));
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 39));
            w = 1'($urandom);
            d = 8'($urandom);
            bus_cycle(a, w, d);
            check_all($sformatf("rnd%0d", i));
        end
        while (ref_cnt != 8'h00) begin
            bus_cycle(16'($urandom_range(0, 63)), 1'b0, 8'h00);
            check_all("pad");
        end
        chk("cnt_wrap", acc_count, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
